// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle main control FSM for the RV32I core.
// It fetches an instruction over an I_REQ/I_ACK handshake and latches it.
// It then decodes the opcode into a 3-bit ALUop class and steps through
// EXEC/MEM/WB, driving the register-file, PC and data-memory strobes.
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN. When it is defined, an
// illegal opcode traps and ILLEGAL is sticky. Otherwise an illegal opcode
// retires as a NOP.
module multicycle_ctrl_fsm #(
   parameter logic [1:0]  RESET_PC_SEL = 2'd0,
   parameter int unsigned MEM_TIMEOUT  = 16
) (
   input  logic        CLK,
   input  logic        RESET_N,
   output logic        I_REQ,
   input  logic        I_ACK,
   input  logic [31:0] I_RDATA,
   output logic [31:0] INSTR,
   output logic [2:0]  ALUop,
   input  logic        BR_TAKEN,
   output logic        D_REQ,
   output logic        D_WE,
   input  logic        D_ACK,
   output logic        REG_WE,
   output logic        PC_WE,
   output logic [1:0]  PC_SEL,
   output logic        RETIRED,
   output logic        MEM_ERR,
   output logic        ILLEGAL
);

   typedef enum logic [2:0] {
      ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_TRAP
   } state_e;

   localparam logic [2:0] ALU_R      = 3'b000;
   localparam logic [2:0] ALU_IARITH = 3'b001;
   localparam logic [2:0] ALU_LOAD   = 3'b010;
   localparam logic [2:0] ALU_STORE  = 3'b011;
   localparam logic [2:0] ALU_BRANCH = 3'b100;
   localparam logic [2:0] ALU_LUI    = 3'b101;
   localparam logic [2:0] ALU_AUIPC  = 3'b110;
   localparam logic [2:0] ALU_JUMP   = 3'b111;

   state_e      state_q, state_d;
   logic [31:0] instr_q, instr_d;
   logic [2:0]  aluop_q, aluop_d;
   logic [1:0]  pc_sel_q, pc_sel_d;
   logic        reg_we_q, reg_we_d;
   logic        pc_we_q, pc_we_d;
   logic        retired_q, retired_d;
   logic [31:0] cnt_q, cnt_d;
`ifdef CTRL_ILLEGAL_TRAP_EN
   logic        illegal_q, illegal_d;
`endif

   logic [2:0]  dec_cls;
   logic        dec_legal;
   logic        branch_exec;
   logic        store_done;
   logic        mem_timeout;

   // Classify the latched opcode into an ALUop class.
   always_comb begin
      dec_legal = 1'b1;
      dec_cls   = ALU_R;
      case (instr_q[6:0])
         7'b0110011: dec_cls = ALU_R;
         7'b0010011: dec_cls = ALU_IARITH;
         7'b0000011: dec_cls = ALU_LOAD;
         7'b0100011: dec_cls = ALU_STORE;
         7'b1100011: dec_cls = ALU_BRANCH;
         7'b0110111: dec_cls = ALU_LUI;
         7'b0010111: dec_cls = ALU_AUIPC;
         7'b1101111: dec_cls = ALU_JUMP;
         7'b1100111: dec_cls = ALU_JUMP;
         default:    dec_legal = 1'b0;
      endcase
   end

   // The branch PC select and the MEM completion strobes depend on inputs
   // sampled in the same cycle, so they are decoded beside the registered
   // strobes rather than registered themselves.
   assign branch_exec = (state_q == ST_EXEC) && (aluop_q == ALU_BRANCH);
   assign store_done  = (state_q == ST_MEM) && D_ACK && (aluop_q == ALU_STORE);
   assign mem_timeout = (state_q == ST_MEM) && !D_ACK && (MEM_TIMEOUT != 0)
                        && (cnt_q == MEM_TIMEOUT);

   // Next-state and next-output logic for every state.
   always_comb begin
      state_d   = state_q;
      instr_d   = instr_q;
      aluop_d   = aluop_q;
      pc_sel_d  = pc_sel_q;
      reg_we_d  = 1'b0;
      pc_we_d   = 1'b0;
      retired_d = 1'b0;
      cnt_d     = cnt_q;
`ifdef CTRL_ILLEGAL_TRAP_EN
      illegal_d = illegal_q;
`endif
      case (state_q)
         ST_FETCH: begin
            if (I_ACK) begin
               instr_d = I_RDATA;
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            if (dec_legal) begin
               aluop_d = dec_cls;
               state_d = ST_EXEC;
               if (dec_cls == ALU_BRANCH) begin
                  pc_we_d   = 1'b1;
                  retired_d = 1'b1;
               end
            end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
               state_d   = ST_TRAP;
               illegal_d = 1'b1;
`else
               aluop_d   = ALU_R;
               state_d   = ST_WB;
               pc_we_d   = 1'b1;
               retired_d = 1'b1;
               pc_sel_d  = 2'd0;
`endif
            end
         end
         ST_EXEC: begin
            case (aluop_q)
               ALU_LOAD, ALU_STORE: begin
                  state_d  = ST_MEM;
                  cnt_d    = '0;
                  pc_sel_d = 2'd0;
               end
               ALU_BRANCH: begin
                  state_d  = ST_FETCH;
                  pc_sel_d = {1'b0, BR_TAKEN};
               end
               default: begin
                  state_d   = ST_WB;
                  reg_we_d  = 1'b1;
                  pc_we_d   = 1'b1;
                  retired_d = 1'b1;
                  if (aluop_q == ALU_JUMP) begin
                     pc_sel_d = instr_q[3] ? 2'd1 : 2'd2;
                  end else begin
                     pc_sel_d = 2'd0;
                  end
               end
            endcase
         end
         ST_MEM: begin
            if (D_ACK) begin
               if (aluop_q == ALU_LOAD) begin
                  state_d   = ST_WB;
                  reg_we_d  = 1'b1;
                  pc_we_d   = 1'b1;
                  retired_d = 1'b1;
               end else begin
                  state_d = ST_FETCH;
               end
            end else if (mem_timeout) begin
               state_d = ST_FETCH;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         ST_WB:   state_d = ST_FETCH;
         ST_TRAP: state_d = ST_TRAP;
         default: state_d = ST_FETCH;
      endcase
   end

   // State and registered-output flops.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q   <= ST_FETCH;
         instr_q   <= '0;
         aluop_q   <= ALU_R;
         pc_sel_q  <= RESET_PC_SEL;
         reg_we_q  <= 1'b0;
         pc_we_q   <= 1'b0;
         retired_q <= 1'b0;
         cnt_q     <= '0;
`ifdef CTRL_ILLEGAL_TRAP_EN
         illegal_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         instr_q   <= instr_d;
         aluop_q   <= aluop_d;
         pc_sel_q  <= pc_sel_d;
         reg_we_q  <= reg_we_d;
         pc_we_q   <= pc_we_d;
         retired_q <= retired_d;
         cnt_q     <= cnt_d;
`ifdef CTRL_ILLEGAL_TRAP_EN
         illegal_q <= illegal_d;
`endif
      end
   end

   assign I_REQ   = (state_q == ST_FETCH);
   assign D_REQ   = (state_q == ST_MEM);
   assign D_WE    = (state_q == ST_MEM) && (aluop_q == ALU_STORE);
   assign INSTR   = instr_q;
   assign ALUop   = aluop_q;
   assign REG_WE  = reg_we_q;
   assign PC_WE   = pc_we_q | store_done | mem_timeout;
   assign RETIRED = retired_q | store_done;
   assign MEM_ERR = mem_timeout;
   assign PC_SEL  = branch_exec ? {1'b0, BR_TAKEN} : pc_sel_q;
`ifdef CTRL_ILLEGAL_TRAP_EN
   assign ILLEGAL = illegal_q;
`else
   assign ILLEGAL = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm: one instruction per vector,
// per-cycle strobe observation, hand-computed expected results.
module tb_multicycle_ctrl_fsm;

   logic        CLK = 1'b0;
   logic        RESET_N;
   logic        I_REQ, I_ACK;
   logic [31:0] I_RDATA, INSTR;
   logic [2:0]  ALUop;
   logic        BR_TAKEN, D_REQ, D_WE, D_ACK;
   logic        REG_WE, PC_WE, RETIRED, MEM_ERR, ILLEGAL;
   logic [1:0]  PC_SEL;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   // Per-instruction observations
   int unsigned pcwe_cycle, pc_we_n, reg_we_n, dreq_n, ret_n, err_n;
   logic [1:0]  pcsel_at;
   logic        dwe_seen, ireq_c2;

   multicycle_ctrl_fsm #(.RESET_PC_SEL(2'd0), .MEM_TIMEOUT(4)) dut (
      .CLK(CLK), .RESET_N(RESET_N),
      .I_REQ(I_REQ), .I_ACK(I_ACK), .I_RDATA(I_RDATA),
      .INSTR(INSTR), .ALUop(ALUop), .BR_TAKEN(BR_TAKEN),
      .D_REQ(D_REQ), .D_WE(D_WE), .D_ACK(D_ACK),
      .REG_WE(REG_WE), .PC_WE(PC_WE), .PC_SEL(PC_SEL),
      .RETIRED(RETIRED), .MEM_ERR(MEM_ERR), .ILLEGAL(ILLEGAL)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Runs one instruction starting in FETCH (#1 after a rising edge).
   // Stops after the PC_WE cycle or after 40 cycles.
   task automatic run_instr(input logic [31:0] w, input int unsigned dwait, input logic br);
      logic done;
      done = 1'b0;
      pcwe_cycle = 0; pc_we_n = 0; reg_we_n = 0; dreq_n = 0; ret_n = 0; err_n = 0;
      pcsel_at = 2'd3; dwe_seen = 1'b0; ireq_c2 = 1'bx;
      for (int unsigned c = 1; c <= 40 && !done; c++) begin
         // Acks outside their states carry junk and must be ignored.
         I_ACK    = 1'b1;
         I_RDATA  = (c == 1) ? w : 32'hFFFF_FFFF;
         D_ACK    = D_REQ ? (dreq_n == dwait) : 1'b1;
         BR_TAKEN = br;
         #1;
         if (c == 2) ireq_c2 = I_REQ;
         if (REG_WE)  reg_we_n++;
         if (D_REQ)   dreq_n++;
         if (D_WE)    dwe_seen = 1'b1;
         if (RETIRED) ret_n++;
         if (MEM_ERR) err_n++;
         if (PC_WE) begin
            pc_we_n++;
            pcsel_at   = PC_SEL;
            pcwe_cycle = c;
            done       = 1'b1;
         end
         @(posedge CLK); #1;
      end
      I_ACK = 1'b0; D_ACK = 1'b0; BR_TAKEN = 1'b0;
   endtask

   task automatic do_vec(input string nm, input logic [31:0] w, input int unsigned dwait,
                         input logic br, input logic [2:0] e_alu, input int unsigned e_cyc,
                         input logic [1:0] e_sel, input int unsigned e_reg,
                         input int unsigned e_dreq, input logic e_dwe,
                         input int unsigned e_err, input int unsigned e_ret);
      run_instr(w, dwait, br);
      check({nm, " ALUop"},   32'(ALUop), 32'(e_alu));
      check({nm, " INSTR"},   INSTR, w);
      check({nm, " latency"}, pcwe_cycle, e_cyc);
      check({nm, " PC_WE n"}, pc_we_n, 1);
      check({nm, " PC_SEL"},  32'(pcsel_at), 32'(e_sel));
      check({nm, " REG_WE n"}, reg_we_n, e_reg);
      check({nm, " D_REQ n"}, dreq_n, e_dreq);
      check({nm, " D_WE"},    32'(dwe_seen), 32'(e_dwe));
      check({nm, " MEM_ERR n"}, err_n, e_err);
      check({nm, " RETIRED n"}, ret_n, e_ret);
      check({nm, " I_REQ drop"}, 32'(ireq_c2), 0);
      check({nm, " I_REQ next"}, 32'(I_REQ), 1);
   endtask

   initial begin
      int unsigned rw;
      RESET_N = 1'b0; I_ACK = 1'b0; I_RDATA = '0; D_ACK = 1'b0; BR_TAKEN = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      check("rst INSTR",   INSTR, 0);
      check("rst ALUop",   32'(ALUop), 0);
      check("rst PC_SEL",  32'(PC_SEL), 0);
      check("rst strobes", {26'd0, REG_WE, PC_WE, RETIRED, MEM_ERR, D_REQ, ILLEGAL}, 0);
      RESET_N = 1'b1;

      //     name       word          dw br alu cyc sel reg dreq dwe err ret
      do_vec("add",    32'h002081B3, 0, 0, 3'd0, 4, 2'd0, 1, 0, 0, 0, 1);
      do_vec("addi",   32'h00108093, 0, 0, 3'd1, 4, 2'd0, 1, 0, 0, 0, 1);
      do_vec("lw w3",  32'h0040A183, 3, 0, 3'd2, 8, 2'd0, 1, 4, 0, 0, 1);
      do_vec("lw w0",  32'h0040A183, 0, 0, 3'd2, 5, 2'd0, 1, 1, 0, 0, 1);
      do_vec("jal",    32'h008000EF, 0, 0, 3'd7, 4, 2'd1, 1, 0, 0, 0, 1);
      do_vec("sw w0",  32'h0020A023, 0, 0, 3'd3, 4, 2'd0, 0, 1, 1, 0, 1);
      do_vec("sw w2",  32'h0020A023, 2, 0, 3'd3, 6, 2'd0, 0, 3, 1, 0, 1);
      do_vec("beq t",  32'h00208463, 0, 1, 3'd4, 3, 2'd1, 0, 0, 0, 0, 1);
      do_vec("beq nt", 32'h00208463, 0, 0, 3'd4, 3, 2'd0, 0, 0, 0, 0, 1);
      do_vec("lui",    32'h123450B7, 0, 0, 3'd5, 4, 2'd0, 1, 0, 0, 0, 1);
      do_vec("auipc",  32'h00000097, 0, 0, 3'd6, 4, 2'd0, 1, 0, 0, 0, 1);
      do_vec("jalr",   32'h000080E7, 0, 0, 3'd7, 4, 2'd2, 1, 0, 0, 0, 1);
      do_vec("lw tmo", 32'h0040A183, 99, 0, 3'd2, 8, 2'd0, 0, 5, 0, 1, 0);

      // Reset in the middle of a load's MEM phase
      I_ACK = 1'b1; I_RDATA = 32'h0040A183;
      @(posedge CLK); #1;
      I_ACK = 1'b0; D_ACK = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      check("mid-MEM D_REQ", 32'(D_REQ), 1);
      RESET_N = 1'b0;
      #1;
      check("arst I_REQ",  32'(I_REQ), 1);
      check("arst D_REQ",  32'(D_REQ), 0);
      check("arst INSTR",  INSTR, 0);
      check("arst ALUop",  32'(ALUop), 0);
      check("arst PC_WE",  32'(PC_WE), 0);
      @(posedge CLK); #1;
      RESET_N = 1'b1;
      rw = 0;
      for (int unsigned k = 0; k < 3; k++) begin
         @(posedge CLK); #1;
         if (REG_WE) rw++;
         check("post-rst I_REQ", 32'(I_REQ), 1);
      end
      check("post-rst REG_WE n", rw, 0);

      // Illegal opcode
`ifdef CTRL_ILLEGAL_TRAP_EN
      run_instr(32'h0000007F, 0, 0);
      check("trap PC_WE n",   pc_we_n, 0);
      check("trap RETIRED n", ret_n, 0);
      check("trap REG_WE n",  reg_we_n, 0);
      check("trap ILLEGAL",   32'(ILLEGAL), 1);
      check("trap I_REQ",     32'(I_REQ), 0);
      repeat (5) @(posedge CLK);
      #1;
      check("trap ILLEGAL sticky", 32'(ILLEGAL), 1);
      RESET_N = 1'b0;
      #1;
      check("trap rst ILLEGAL", 32'(ILLEGAL), 0);
      @(posedge CLK); #1;
      RESET_N = 1'b1;
      do_vec("add rec", 32'h002081B3, 0, 0, 3'd0, 4, 2'd0, 1, 0, 0, 0, 1);
`else
      do_vec("lw pre", 32'h0040A183, 0, 0, 3'd2, 5, 2'd0, 1, 1, 0, 0, 1);
      do_vec("nop ill", 32'h0000007F, 0, 0, 3'd0, 3, 2'd0, 0, 0, 0, 0, 1);
      check("nop ILLEGAL", 32'(ILLEGAL), 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
